// File: rtl/alu_share_arbiter_pkg.sv
// Core-wide datapath types shared by the ALU, the ALU-share arbiter and its requesters.
package CorePack;

    typedef logic [63:0] data_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_ADDW = 4'd10,
        ALU_SUBW = 4'd11,
        ALU_SLLW = 4'd12,
        ALU_SRLW = 4'd13,
        ALU_SRAW = 4'd14
    } alu_op_enum;

    typedef struct packed {
        data_t      a;
        data_t      b;
        alu_op_enum op;
    } alu_req_t;

    function automatic data_t sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Shared 64-bit integer ALU; purely combinational, one operation per request.
module Alu
    import CorePack::*;
(
    input  alu_req_t i_req,
    output data_t    o_res
);

    logic [31:0]        w_addw;
    logic [31:0]        w_subw;
    logic [31:0]        w_sllw;
    logic [31:0]        w_srlw;
    logic signed [31:0] w_sraw;

    // W-ops work on the low word; only SRLW is zero-extended back to 64 bits.
    assign w_addw = i_req.a[31:0] + i_req.b[31:0];
    assign w_subw = i_req.a[31:0] - i_req.b[31:0];
    assign w_sllw = i_req.a[31:0] << i_req.b[4:0];
    assign w_srlw = i_req.a[31:0] >> i_req.b[4:0];
    assign w_sraw = $signed(i_req.a[31:0]) >>> i_req.b[4:0];

    always_comb begin
        o_res = '0;
        case (i_req.op)
            ALU_ADD:  o_res = i_req.a + i_req.b;
            ALU_SUB:  o_res = i_req.a - i_req.b;
            ALU_AND:  o_res = i_req.a & i_req.b;
            ALU_OR:   o_res = i_req.a | i_req.b;
            ALU_XOR:  o_res = i_req.a ^ i_req.b;
            ALU_SLL:  o_res = i_req.a << i_req.b[5:0];
            ALU_SRL:  o_res = i_req.a >> i_req.b[5:0];
            ALU_SRA:  o_res = $signed(i_req.a) >>> i_req.b[5:0];
            ALU_SLT:  o_res = {63'b0, $signed(i_req.a) < $signed(i_req.b)};
            ALU_SLTU: o_res = {63'b0, i_req.a < i_req.b};
            ALU_ADDW: o_res = sext32(w_addw);
            ALU_SUBW: o_res = sext32(w_subw);
            ALU_SLLW: o_res = sext32(w_sllw);
            ALU_SRLW: o_res = {32'b0, w_srlw};
            ALU_SRAW: o_res = sext32(w_sraw);
            default:  o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr, wrapping mod N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;

    // Scan from the farthest offset down so the candidate nearest ptr is written last and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        w_sum = '0;
        w_j   = '0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                w_sum = {1'b0, ptr} + (IW + 1)'(k);
                if (w_sum >= (IW + 1)'(N)) begin
                    w_sum = w_sum - (IW + 1)'(N);
                end
                w_j = w_sum[IW-1:0];
                if (req[w_j]) begin
                    grant      = '0;
                    grant[w_j] = 1'b1;
                    idx        = w_j;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters; the winner's result returns through a single-entry response register.
module alu_share_arbiter
    import CorePack::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  data_t [NUM_REQ-1:0]             req_a,
    input  data_t [NUM_REQ-1:0]             req_b,
    input  alu_op_enum [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output data_t                           rsp_res,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [TAG_W-1:0]                rsp_tag
);

    logic             r_rspValid;
    data_t            r_rspRes;
    logic [ID_W-1:0]  r_rspId;
    logic [TAG_W-1:0] r_rspTag;
    logic [ID_W-1:0]  r_ptr;

    logic             w_canIssue;
    logic             w_fire;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_ptrNext;
    alu_req_t         w_aluReq;
    data_t            w_aluRes;

    // Draining and refilling the response slot in the same cycle keeps one op per cycle.
    assign w_canIssue = !r_rspValid || rsp_ready;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req   (req_valid),
        .en    (w_canIssue && !rst),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_fire    = |w_grant;
    assign w_ptrNext = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    assign w_aluReq = '{a: req_a[w_idx], b: req_b[w_idx], op: req_op[w_idx]};

    Alu u_alu (
        .i_req (w_aluReq),
        .o_res (w_aluRes)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspValid <= 1'b0;
            r_rspRes   <= '0;
            r_rspId    <= '0;
            r_rspTag   <= '0;
            r_ptr      <= '0;
        end else if (w_fire) begin
            r_rspValid <= 1'b1;
            r_rspRes   <= w_aluRes;
            r_rspId    <= w_idx;
            r_rspTag   <= req_tag[w_idx];
            r_ptr      <= w_ptrNext;
        end else if (rsp_ready) begin
            r_rspValid <= 1'b0;
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_res   = r_rspRes;
    assign rsp_id    = r_rspId;
    assign rsp_tag   = r_rspTag;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between NUM_REQ requesters, e.g. the integer pipe, the address-generation unit and a debug/CSR port.
- Performs round-robin arbitration over valid/ready request channels and launches one operation per cycle.
- Captures the ALU result in a single-entry output register that carries the winner's ID and tag back over a valid/ready response channel.
- Sits between the decode/issue stage and the shared ALU module inside the core.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- TAG_W, 4, width of the opaque per-request tag returned with the result.
- ID_W, $clog2(NUM_REQ), width of the requester index field.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ x 64 (CorePack::data_t)  operand a per requester.
- req_b  input  NUM_REQ x 64 (CorePack::data_t)  operand b per requester.
- req_op  input  NUM_REQ x CorePack::alu_op_enum  operation per requester.
- req_tag  input  NUM_REQ x TAG_W  tag per requester.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_res  output  64  ALU result.
- rsp_id  output  ID_W  index of the requester that issued the op.
- rsp_tag  output  TAG_W  tag echoed from the request.

Behaviour:
- Reset, asynchronous, active-high, effective immediately:
  - rsp_valid=0; rsp_res, rsp_id, rsp_tag = 0.
  - Round-robin pointer = 0.
  - req_ready = 0 while rst is asserted.
  - Reset mid-operation discards the buffered result. No request is accepted during reset.
- Slot availability: can_issue = !rsp_valid || rsp_ready. This allows a full-throughput drain-and-refill in the same cycle.
- Grant (combinational):
  - If can_issue, grant goes to the first asserted req_valid at or after the pointer, scanning upward with wrap-around mod NUM_REQ.
  - req_ready[i] = grant[i].
  - No grant if can_issue=0 or no valid requests.
- A handshake completes when req_valid[i] && req_ready[i]. The winner's a, b and op drive the ALU in that cycle.
- Next edge after a handshake:
  - rsp_res = ALU result; rsp_id = i; rsp_tag = req_tag[i]; rsp_valid = 1.
  - Pointer = (i+1) mod NUM_REQ.
  - Latency is exactly 1 cycle from handshake to rsp_valid.
- If rsp_valid && rsp_ready and there is no new grant, rsp_valid goes to 0 on the next edge.
- If rsp_valid && !rsp_ready:
  - The result register holds rsp_res, rsp_id and rsp_tag stable.
  - req_ready is all zero; no grant.
- Pointer changes only on a completed handshake.
- Fairness: a continuously-valid requester is granted within NUM_REQ-1 other grants.
- Requester rules: once req_valid is raised it stays high with stable payload until it sees req_ready. The bench checks this as an assertion.
- Arithmetic and widths:
  - Results are exactly the ALU's: 64-bit ops, and W-ops sign-extended from 32 bits except SRLW, which is zero-extended.
  - An undefined op yields 0.
  - The arbiter does not alter operands.
- Throughput: 1 op/cycle when rsp_ready is held high.

Decomposition:
- CorePack gets an alu_req_t struct {data_t a; data_t b; alu_op_enum op}. TAG_W stays a module parameter.
- Sub-module rr_arbiter #(N): inputs req[N], en, ptr; output one-hot grant[N] plus a binary index. Purely combinational; the pointer register lives in the parent.
- The existing ALU module is instantiated once, unchanged.

Test Plan:
- Single requester: req1 ADD a=5, b=7, tag=3, rsp_ready=1. Expect req_ready[1] the same cycle; next cycle rsp_valid=1, res=12, id=1, tag=3.
- All three requesters valid continuously, pointer=0, rsp_ready=1. Expect grant order 0,1,2,0,1,2 on consecutive cycles, one response per cycle.
- Backpressure:
  - Req0 SUBW a=0, b=1 completes; rsp_ready held 0 for 3 cycles while req1 and req2 are valid.
  - Expect req_ready=0 and rsp_res=0xFFFF_FFFF_FFFF_FFFF stable throughout.
  - When rsp_ready=1, req1 is granted the same cycle.
- Op coverage through port 2:
  - SRLW a=0xFFFF_FFFF_8000_0000, b=4 -> 0x0000_0000_0800_0000.
  - SRAW same operands -> 0xFFFF_FFFF_F800_0000.
  - SLT a=-1, b=0 -> 1.
- Reset mid-flight: assert rst asynchronously while rsp_valid=1 with pointer=2. Expect rsp_valid=0 immediately; after release, pointer=0, so req0 wins over req2 when both are valid.
- Starvation: req0 valid every cycle, req2 raised once. Expect req2 granted within 2 grants and its tag returned intact.
